// File: rtl/stream_mux_pkg.sv
// Shared types for the round-robin stream multiplexer: arbitration mode and packet-lock state.
package stream_mux_pkg;
  typedef enum logic {MODE_STATIC = 1'b0, MODE_RR = 1'b1} mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} st_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester after ptr, wrapping modulo N_CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);
  logic [SEL_W-1:0] start;
  logic [N_CH-1:0]  req_rot;
  logic [N_CH-1:0]  first_rot;

  genvar gi, gj;

  // Start one past ptr; wrap at N_CH-1 rather than at 2**SEL_W.
  assign start   = (ptr >= SEL_W'(N_CH - 1)) ? '0 : ptr + 1'b1;
  assign req_rot = N_CH'({req, req} >> start);

  assign first_rot[0] = req_rot[0];
  for (gi = 1; gi < N_CH; gi++) begin : g_first
    assign first_rot[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
  end

  assign gnt = N_CH'(({first_rot, first_rot} << start) >> N_CH);

  // One-hot to index: bit b of the index is set by every channel whose number has bit b set.
  for (gi = 0; gi < SEL_W; gi++) begin : g_enc
    logic [N_CH-1:0] mask;
    for (gj = 0; gj < N_CH; gj++) begin : g_bit
      assign mask[gj] = 1'((gj >> gi) & 1);
    end
    assign gnt_idx[gi] = |(gnt & mask);
  end
endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with registered output, static or round-robin selection,
// and packet-locked arbitration (a packet is never interleaved with another channel's beats).
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);
  st_e              st_reg;
  logic [SEL_W-1:0] lock_ch_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_last_reg;
  logic [SEL_W-1:0] out_ch_reg;

  logic [N_CH-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic [N_CH-1:0]  sel_oh;
  logic [N_CH-1:0]  lock_oh;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic [N_CH-1:0]  accept;
  logic [WIDTH-1:0] data_sel;
  logic             load;
  logic             xfer;
  logic             xfer_last;

  genvar gi, gj;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // A sel value of N_CH or above decodes to no bit at all, hence no grant.
  for (gi = 0; gi < N_CH; gi++) begin : g_oh
    assign sel_oh[gi]  = (sel == SEL_W'(gi));
    assign lock_oh[gi] = (lock_ch_reg == SEL_W'(gi));
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (st_reg == ST_LOCKED) begin
      grant     = lock_oh;
      grant_idx = lock_ch_reg;
    end else if (mode_e'(mode) == MODE_RR) begin
      grant     = arb_gnt;
      grant_idx = arb_idx;
    end else begin
      grant     = sel_oh;
      grant_idx = sel;
    end
  end

  assign load      = !out_valid_reg || out_ready;
  assign in_ready  = rst ? '0 : (grant & {N_CH{load}});
  assign accept    = in_valid & in_ready;
  assign xfer      = |accept;
  assign xfer_last = |(accept & in_last);

  // AND-OR select, one output bit at a time, using the one-hot grant.
  for (gi = 0; gi < WIDTH; gi++) begin : g_dsel
    logic [N_CH-1:0] col;
    for (gj = 0; gj < N_CH; gj++) begin : g_ch
      assign col[gj] = in_data[gj*WIDTH + gi];
    end
    assign data_sel[gi] = |(col & grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg        <= ST_IDLE;
      lock_ch_reg   <= '0;
      ptr_reg       <= SEL_W'(N_CH - 1);
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_ch_reg    <= '0;
    end else begin
      if (load) begin
        out_valid_reg <= xfer;
        if (xfer) begin
          out_data_reg <= data_sel;
          out_last_reg <= xfer_last;
          out_ch_reg   <= grant_idx;
        end
      end
      // Pointer advances on every packet end, even in static mode, so a switch to RR stays fair.
      if (xfer) begin
        if (xfer_last) begin
          st_reg  <= ST_IDLE;
          ptr_reg <= grant_idx;
        end else begin
          st_reg      <= ST_LOCKED;
          lock_ch_reg <= grant_idx;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_ch    = out_ch_reg;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: vector table, hand-written packet sequences,
// a 3-channel instance for wrap checks, and randomized traffic against a behavioural model.
module tb_stream_mux_rr;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;

  logic        rst3, mode3, out_ready3, out_valid3, out_last3;
  logic [1:0]  sel3, out_ch3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [23:0] in_data3;
  logic [7:0]  out_data3;

  int total = 0;
  int pass  = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_last(in_last3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      pass++;
      if (verbose) $display("[%0t] %s ok: %h", $time, name, act);
    end else begin
      $display("[%0t] FAIL %s: got %h expected %h", $time, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural reference: packet lock, modulo-N round-robin search, one-deep output holding.
  bit         m_locked, m_ov, m_ol;
  int         m_lock, m_ptr;
  logic [7:0] m_od;
  logic [1:0] m_oc;

  function automatic int m_grant();
    if (m_locked) return m_lock;
    if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g;
    g = m_grant();
    if (rst || g < 0 || !(!m_ov || out_ready)) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic m_update();
    int g;
    bit ld, xf;
    if (rst) begin
      m_locked = 1'b0; m_lock = 0; m_ptr = N - 1;
      m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_oc = '0;
    end else begin
      g  = m_grant();
      ld = !m_ov || out_ready;
      xf = (g >= 0) && ld && in_valid[g];
      if (ld) m_ov = xf;
      if (xf) begin
        m_od = 8'(in_data >> (8 * g));
        m_ol = in_last[g];
        m_oc = 2'(g);
        if (in_last[g]) begin m_locked = 1'b0; m_ptr = g; end
        else begin m_locked = 1'b1; m_lock = g; end
      end
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       oready;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[1] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[2] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[3] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[4] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[5] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};

    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_last = 4'hF;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10}; out_ready = 1'b1;
    rst3 = 1'b1; mode3 = 1'b1; sel3 = 2'd0; in_valid3 = '0; in_last3 = '0;
    in_data3 = {8'h32, 8'h31, 8'h30}; out_ready3 = 1'b1;
    tick(); tick();

    // Reset state while rst is still high
    #1;
    chk("rst_ready", in_ready, 4'b0000);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_odata", out_data, 8'h00);
    chk("rst_olast", out_last, 1'b0);
    chk("rst_och", out_ch, 2'd0);
    rst = 1'b0;

    // Round-robin fairness, all channels single-beat
    foreach (tbl[i]) begin
      in_valid = tbl[i].valid; in_last = tbl[i].last; out_ready = tbl[i].oready;
      #1;
      chk($sformatf("rr%0d_ready", i), in_ready, tbl[i].exp_ready);
      tick();
      chk($sformatf("rr%0d_beat", i), {out_valid, out_ch, out_data},
          {tbl[i].exp_ov, tbl[i].exp_ch, tbl[i].exp_data});
    end

    // Packet lock on ch2, including a bubble where ch2 drops valid
    in_valid = 4'b0111; in_last = 4'b0011;
    #1; chk("lock_first_ready", in_ready, 4'b0100);
    tick(); chk("lock_b1", {out_valid, out_ch, out_last}, {1'b1, 2'd2, 1'b0});
    in_valid = 4'b0011;
    #1; chk("lock_hold_ready", in_ready, 4'b0100);
    tick(); chk("lock_bubble_ov", out_valid, 1'b0);
    in_valid = 4'b0111;
    tick(); chk("lock_b2", {out_valid, out_ch, out_last}, {1'b1, 2'd2, 1'b0});
    in_last = 4'b0111;
    tick(); chk("lock_b3", {out_valid, out_ch, out_last}, {1'b1, 2'd2, 1'b1});
    #1; chk("lock_next_ready", in_ready, 4'b0001);
    tick(); chk("lock_next_ch", out_ch, 2'd0);

    // Backpressure holds A5 on the output
    in_data = {8'h13, 8'h12, 8'hA5, 8'h10}; in_valid = 4'b0010; in_last = 4'hF;
    tick(); chk("bp_load", {out_valid, out_ch, out_data}, {1'b1, 2'd1, 8'hA5});
    out_ready = 1'b0; in_valid = 4'hF; in_data = {8'h13, 8'h12, 8'h5A, 8'h10};
    for (int c = 0; c < 5; c++) begin
      #1; chk($sformatf("bp_ready%0d", c), in_ready, 4'b0000);
      tick(); chk($sformatf("bp_hold%0d", c), {out_valid, out_ch, out_data}, {1'b1, 2'd1, 8'hA5});
    end
    out_ready = 1'b1;
    #1; chk("bp_release_ready", in_ready, 4'b0100);
    tick(); chk("bp_release_beat", {out_valid, out_ch, out_data}, {1'b1, 2'd2, 8'h12});
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // Static mode: sel change mid-packet is deferred to the packet boundary
    mode = 1'b0; sel = 2'd1; in_last = 4'b0000;
    tick(); chk("st_b1", {out_valid, out_ch, out_data}, {1'b1, 2'd1, 8'h11});
    sel = 2'd3;
    #1; chk("st_midsel_ready", in_ready, 4'b0010);
    tick(); chk("st_b2", out_ch, 2'd1);
    in_last = 4'b0010;
    tick(); chk("st_b3", {out_ch, out_last}, {2'd1, 1'b1});
    in_last = 4'hF;
    #1; chk("st_sel3_ready", in_ready, 4'b1000);
    tick(); chk("st_sel3_beat", {out_valid, out_ch, out_data}, {1'b1, 2'd3, 8'h13});

    // Reset while locked on ch1
    mode = 1'b1; in_valid = 4'b0010; in_last = 4'b0000;
    tick(); chk("rm_locked", {out_valid, out_ch}, {1'b1, 2'd1});
    rst = 1'b1;
    tick();
    #1; chk("rm_after", {out_valid, out_ch, in_ready}, {1'b1 ^ 1'b1, 2'd0, 4'b0000});
    rst = 1'b0; in_valid = 4'hF; in_last = 4'hF;
    #1; chk("rm_release_ready", in_ready, 4'b0001);
    tick(); chk("rm_release_beat", {out_valid, out_ch}, {1'b1, 2'd0});

    // Three-channel instance: wrap modulo 3 and sel out of range
    in_valid = 4'b0000;
    rst3 = 1'b0; in_valid3 = 3'b101; in_last3 = 3'b111;
    #1; chk("n3_ready0", in_ready3, 3'b001);
    tick(); chk("n3_ch0", {out_valid3, out_ch3, out_data3}, {1'b1, 2'd0, 8'h30});
    #1; chk("n3_ready1", in_ready3, 3'b100);
    tick(); chk("n3_ch2", {out_valid3, out_ch3, out_data3}, {1'b1, 2'd2, 8'h32});
    #1; chk("n3_wrap_ready", in_ready3, 3'b001);
    mode3 = 1'b0; sel3 = 2'd3;
    #1; chk("n3_sel_oob", in_ready3, 3'b000);
    sel3 = 2'd2;
    #1; chk("n3_sel2", in_ready3, 3'b100);
    in_valid3 = '0;

    // Randomized traffic against the behavioural model
    verbose = 1'b0;
    rst = 1'b1;
    @(posedge clk); m_update(); @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom & $urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      #1;
      chk("rand_ready", in_ready, m_ready());
      chk("rand_ovalid", out_valid, m_ov);
      if (m_ov) chk("rand_beat", {out_data, out_last, out_ch}, {m_od, m_ol, m_oc});
      @(posedge clk); m_update(); @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
